// File: rtl/link_pkg.sv
// Shared definitions for the 5-bit character + parity link.
// Both the transmit block and the receive-side parity checker import this
// package, so they use the same state encoding and parity rule.
package link_pkg;

  localparam int CHAR_W     = 5;
  localparam int FRAME_BITS = 8;

  // Serial frame phases: start, five data bits, parity, stop.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } link_state_e;

  // Even parity over the character, inverted when the link runs odd parity.
  function automatic logic parity5(input logic [CHAR_W-1:0] char_val, input logic odd);
    return (^char_val) ^ odd;
  endfunction

endpackage

// File: rtl/char_parity_tx_bit_timer.sv
// Bit-period timer for the serial link.
// Counts CLKS_PER_BIT clocks per bit while a frame is running. bit_end marks
// the last clock of a bit; bit_pre_end marks the clock before it.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
  localparam bit               HAS_PRE  = (CLKS_PER_BIT > 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: cleared on frame start or when idle, wraps at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Clock counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end     = run && (cnt_q == LAST_CNT);
  assign bit_pre_end = run && HAS_PRE && (cnt_q == PRE_CNT);

endmodule

// File: rtl/char_parity_tx.sv
// Transmit end of the 5-bit character + parity link.
// Accepts a character on a valid/ready handshake, holds it with its parity bit
// as a registered parallel pair, and serialises the frame
// start, D0..D4 (LSB first), parity, stop on tx_serial.
module char_parity_tx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              char_valid,
  input  logic              inject_err,
  output logic              char_ready,
  output logic [CHAR_W-1:0] e_out,
  output logic              p_out,
  output logic              tx_serial,
  output logic              busy,
  output logic              frame_done
);

  localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);

  link_state_e       state_q, state_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CHAR_W-1:0] e_q, e_d;
  logic              p_q, p_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic accept;
  logic bit_end;
  logic bit_pre_end;

  assign accept = char_valid && ready_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state_q != IDLE),
    .restart    (accept),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  // Frame sequencing: next state, shift register, line level and status flags.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    e_d       = e_q;
    p_d       = p_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          e_d       = char_in;
          p_d       = parity5(char_in, PARITY_ODD) ^ inject_err;
          shift_d   = char_in;
          bit_idx_d = 3'd0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd4) begin
            state_d = PARITY;
            tx_d    = p_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[CHAR_W-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          done_d  = SINGLE_CLK;
        end
      end
      STOP: begin
        if (!SINGLE_CLK && bit_pre_end) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      e_q       <= '0;
      p_q       <= PARITY_ODD;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      e_q       <= e_d;
      p_q       <= p_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign char_ready = ready_q;
  assign e_out      = e_q;
  assign p_out      = p_q;
  assign tx_serial  = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_char_parity_tx.sv
// Self-checking bench for char_parity_tx: even-parity 4-clock link, an
// odd-parity instance, and a 1-clock-per-bit instance.
module tb_char_parity_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] char_in;
  logic       char_valid;
  logic       inject_err;
  logic       char_ready;
  logic [4:0] e_out;
  logic       p_out;
  logic       tx_serial;
  logic       busy;
  logic       frame_done;

  logic [4:0] odd_char;
  logic       odd_valid;
  logic       odd_ready;
  logic [4:0] odd_e_out;
  logic       odd_p_out;
  logic       odd_tx;
  logic       odd_busy;
  logic       odd_done;

  logic [4:0] fast_char;
  logic       fast_valid;
  logic       fast_ready;
  logic [4:0] fast_e_out;
  logic       fast_p_out;
  logic       fast_tx;
  logic       fast_busy;
  logic       fast_done;

  char_parity_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .inject_err(inject_err), .char_ready(char_ready), .e_out(e_out), .p_out(p_out),
    .tx_serial(tx_serial), .busy(busy), .frame_done(frame_done)
  );

  char_parity_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .char_in(odd_char), .char_valid(odd_valid),
    .inject_err(1'b0), .char_ready(odd_ready), .e_out(odd_e_out), .p_out(odd_p_out),
    .tx_serial(odd_tx), .busy(odd_busy), .frame_done(odd_done)
  );

  char_parity_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .char_in(fast_char), .char_valid(fast_valid),
    .inject_err(1'b0), .char_ready(fast_ready), .e_out(fast_e_out), .p_out(fast_p_out),
    .tx_serial(fast_tx), .busy(fast_busy), .frame_done(fast_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] ch;
    logic       inj;
    logic       exp_p;
    logic [7:0] exp_line;
  } vec_t;

  vec_t vecs[4];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [4:0] ch, input logic inj);
    @(negedge clk);
    char_in    = ch;
    inject_err = inj;
    char_valid = 1'b1;
  endtask

  // Samples one 32-cycle frame on the main DUT; bit k sampled mid-bit.
  task automatic capture_frame(input bit release_valid, output logic [7:0] line,
                               output int done_cycle, output logic [1:0] first);
    line       = '0;
    done_cycle = 0;
    first      = '0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 1) first = {busy, tx_serial};
      if (((c - 1) % 4) == 1) line[(c - 1) / 4] = tx_serial;
      if (frame_done && done_cycle == 0) done_cycle = c;
      if (release_valid) begin
        if (c == 1) char_valid = 1'b0;
        else if (c == 10) char_valid = 1'b1;
        else if (c == 11) char_valid = 1'b0;
      end
    end
  endtask

  logic [7:0] line;
  logic [1:0] first;
  int         dc;
  logic       fd_seen;

  initial begin
    vecs[0] = '{ch: 5'b10110, inj: 1'b0, exp_p: 1'b1, exp_line: 8'b11101100};
    vecs[1] = '{ch: 5'b00000, inj: 1'b0, exp_p: 1'b0, exp_line: 8'b10000000};
    vecs[2] = '{ch: 5'b11111, inj: 1'b0, exp_p: 1'b1, exp_line: 8'b11111110};
    vecs[3] = '{ch: 5'b00011, inj: 1'b1, exp_p: 1'b1, exp_line: 8'b11000110};

    rst_n      = 1'b0;
    char_in    = '0;
    char_valid = 1'b0;
    inject_err = 1'b0;
    odd_char   = '0;
    odd_valid  = 1'b0;
    fast_char  = '0;
    fast_valid = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_tx", tx_serial, 1'b1);
    check_val("rst_ready", char_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", frame_done, 1'b0);
    check_val("rst_e", e_out, 5'd0);
    check_val("rst_p", p_out, 1'b0);
    check_val("rst_odd_p", odd_p_out, 1'b1);
    check_val("rst_odd_status", {odd_tx, odd_ready, odd_busy, odd_done}, 4'b1100);
    check_val("rst_fast_status", {fast_tx, fast_ready, fast_busy, fast_done}, 4'b1100);
    check_val("rst_fast_ep", {fast_e_out, fast_p_out}, 6'd0);
    rst_n = 1'b1;

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].ch, vecs[i].inj);
      capture_frame(1'b1, line, dc, first);
      check_val($sformatf("v%0d_e", i), e_out, vecs[i].ch);
      check_val($sformatf("v%0d_p", i), p_out, vecs[i].exp_p);
      check_val($sformatf("v%0d_line", i), line, vecs[i].exp_line);
      check_val($sformatf("v%0d_done_cycle", i), dc, 32);
      check_val($sformatf("v%0d_start", i), first, 2'b10);
      check_val($sformatf("v%0d_rx_invalid", i), ^{e_out, p_out}, vecs[i].inj);
      @(negedge clk);
      check_val($sformatf("v%0d_idle", i), {char_ready, busy, tx_serial, frame_done}, 4'b1010);
    end
    inject_err = 1'b0;

    // Back-to-back with char_valid held high.
    start_frame(5'h05, 1'b0);
    capture_frame(1'b0, line, dc, first);
    check_val("b2b1_line", line, 8'b10001010);
    check_val("b2b1_done_cycle", dc, 32);
    char_in = 5'h1A;
    @(negedge clk);
    check_val("b2b_gap", {char_ready, busy, tx_serial}, 3'b101);
    check_val("b2b_e_hold", e_out, 5'h05);
    capture_frame(1'b1, line, dc, first);
    check_val("b2b2_start", first, 2'b10);
    check_val("b2b2_line", line, 8'b11110100);
    check_val("b2b2_done_cycle", dc, 32);
    check_val("b2b2_ep", {e_out, p_out}, {5'h1A, 1'b1});
    repeat (2) @(negedge clk);
    check_val("no_extra_frame", {busy, char_ready}, 2'b01);

    // Reset during the third data bit.
    start_frame(5'b10110, 1'b0);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (13) @(negedge clk);
    check_val("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_status", {tx_serial, busy, char_ready}, 3'b101);
    check_val("midrst_ep", {e_out, p_out}, 6'd0);
    fd_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      fd_seen = fd_seen | frame_done;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fd_seen = fd_seen | frame_done;
    end
    check_val("midrst_no_done", fd_seen, 1'b0);
    start_frame(5'h05, 1'b0);
    capture_frame(1'b1, line, dc, first);
    check_val("post_rst_line", line, 8'b10001010);
    check_val("post_rst_done_cycle", dc, 32);

    // Odd parity instance.
    @(negedge clk);
    odd_char  = 5'b00000;
    odd_valid = 1'b1;
    @(negedge clk);
    odd_valid = 1'b0;
    check_val("odd_zero_p", odd_p_out, 1'b1);
    repeat (34) @(negedge clk);
    odd_char  = 5'b11111;
    odd_valid = 1'b1;
    @(negedge clk);
    odd_valid = 1'b0;
    check_val("odd_ones_p", odd_p_out, 1'b0);
    check_val("odd_ones_e", odd_e_out, 5'b11111);

    // One clock per bit.
    @(negedge clk);
    fast_char  = 5'b01001;
    fast_valid = 1'b1;
    line = '0;
    dc   = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) fast_valid = 1'b0;
      line[c - 1] = fast_tx;
      if (fast_done && dc == 0) dc = c;
    end
    check_val("fast_line", line, 8'b10010010);
    check_val("fast_done_cycle", dc, 8);
    check_val("fast_p", fast_p_out, 1'b0);
    @(negedge clk);
    check_val("fast_idle", {fast_ready, fast_busy, fast_tx}, 3'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
